// File: rtl/exe_div.sv
// Multi-cycle RV32M divider for the EXE stage: radix-2 restoring, one quotient bit per cycle.
// Holds the pipeline via stall_req_o and emits a one-cycle result pulse for writeback.
//
// state | meaning
// IDLE  | waiting for a divide/remainder op
// CALC  | one restoring step per clock, DATA_WIDTH steps in total
// DONE  | result_o/reg_waddr_o valid for exactly one cycle
module exe_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  input  logic [4:0]            reg_waddr_i,
  input  logic                  flush_i,
  output logic                  stall_req_o,
  output logic                  busy_o,
  output logic                  result_valid_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [4:0]            reg_waddr_o
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         count;
  logic                  op_rem;
  logic                  neg_q;
  logic                  neg_r;
  logic [4:0]            waddr_q;
  logic [DATA_WIDTH-1:0] dvd_q;
  logic [DATA_WIDTH-1:0] dsr_q;
  logic [DATA_WIDTH-1:0] rem_q;

  logic                  sgn_op;
  logic                  sign1;
  logic                  sign2;
  logic [DATA_WIDTH-1:0] abs1;
  logic [DATA_WIDTH-1:0] abs2;
  logic                  div0;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] special_res;
  logic [DATA_WIDTH:0]   rem_sh;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] rem_nx;
  logic [DATA_WIDTH-1:0] quo_nx;
  logic [DATA_WIDTH-1:0] fix_res;

  always_comb begin
    sgn_op = ~op_i[0];
    sign1  = sgn_op & op1_i[DATA_WIDTH-1];
    sign2  = sgn_op & op2_i[DATA_WIDTH-1];
    abs1   = sign1 ? -op1_i : op1_i;
    abs2   = sign2 ? -op2_i : op2_i;
    div0   = (op2_i == '0);
    ovf    = sgn_op & (op1_i == INT_MIN) & (op2_i == '1);
    if (div0)
      special_res = op_i[1] ? op1_i : '1;
    else
      special_res = op_i[1] ? '0 : INT_MIN;
  end

  // Quotient bits shift into the dividend register as its bits shift out.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[DATA_WIDTH-1]};
    q_bit   = (rem_sh >= {1'b0, dsr_q});
    rem_nx  = q_bit ? DATA_WIDTH'(rem_sh - {1'b0, dsr_q}) : rem_sh[DATA_WIDTH-1:0];
    quo_nx  = {dvd_q[DATA_WIDTH-2:0], q_bit};
    if (op_rem)
      fix_res = neg_r ? -rem_nx : rem_nx;
    else
      fix_res = neg_q ? -quo_nx : quo_nx;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      count       <= '0;
      op_rem      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      waddr_q     <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      result_o    <= '0;
      reg_waddr_o <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            op_rem  <= op_i[1];
            waddr_q <= reg_waddr_i;
            dvd_q   <= abs1;
            dsr_q   <= abs2;
            neg_q   <= sign1 ^ sign2;
            neg_r   <= sign1;
            rem_q   <= '0;
            count   <= '0;
            if (div0 || ovf) begin
              result_o    <= special_res;
              reg_waddr_o <= reg_waddr_i;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          dvd_q <= quo_nx;
          count <= count + CW'(1);
          if (count == CW'(DATA_WIDTH-1)) begin
            result_o    <= fix_res;
            reg_waddr_o <= waddr_q;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_req_o    = ((state == IDLE) & start_i & ~flush_i) | (state == CALC);
  assign busy_o         = (state != IDLE);
  assign result_valid_o = (state == DONE);

endmodule
